// File: rtl/spi_chip_sequencer.sv
// spi_chip_sequencer: SPI mode-0 master that visits each puzzle chip in turn.
// Ports: start/busy/done pass control, chip_idx, SPI bus (sclk/mosi/miso/ss_n),
// rx_* byte stream to the solver, result_* handshake from the solver.
module spi_chip_sequencer #(
  parameter int NUM_CHIPS    = 2,
  parameter int CLK_DIV      = 4,
  parameter int RESULT_BYTES = 2,
  parameter int SS_GUARD     = 4,
  localparam int CIW = (NUM_CHIPS > 1) ? $clog2(NUM_CHIPS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic [CIW-1:0]            chip_idx,
  output logic                      spi_sclk,
  output logic                      spi_mosi,
  input  logic                      spi_miso,
  output logic [NUM_CHIPS-1:0]      spi_ss_n,
  output logic [7:0]                rx_data,
  output logic                      rx_last,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  input  logic [RESULT_BYTES*8-1:0] result_data,
  input  logic                      result_valid,
  output logic                      result_ready
);

  localparam int RW = RESULT_BYTES * 8;
  localparam int BW = $clog2(RW + 1);
  localparam int DW = $clog2(CLK_DIV);
  localparam int GW = $clog2(SS_GUARD + 1);

  localparam logic [DW-1:0]  DIV_MAX  = DW'(CLK_DIV - 1);
  localparam logic [GW-1:0]  G_MAX    = GW'(SS_GUARD - 1);
  localparam logic [BW-1:0]  RX_LASTB = BW'(7);
  localparam logic [BW-1:0]  TX_LASTB = BW'(RW - 1);
  localparam logic [CIW-1:0] LAST     = CIW'(NUM_CHIPS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_RX_BIT,
    S_RX_HAND,
    S_WAIT_RES,
    S_TX_BIT,
    S_DESELECT,
    S_GAP
  } state_e;

  state_e         state_q, state_d;
  logic [CIW-1:0] chip_q, chip_d;
  logic [DW-1:0]  div_q, div_d;
  logic [BW-1:0]  bit_q, bit_d;
  logic [GW-1:0]  guard_q, guard_d;
  logic           sclk_q, sclk_d;
  logic           mosi_q, mosi_d;
  logic [7:0]     shift_q, shift_d;
  logic [7:0]     rxd_q, rxd_d;
  // MSB goes straight to mosi on latch, so only the lower bits are kept
  logic [RW-2:0]  tx_q, tx_d;
  logic           done_q, done_d;

  logic tick;
  logic rise;
  logic fall;

  assign tick = (div_q == DIV_MAX);
  assign rise = tick & ~sclk_q;
  assign fall = tick & sclk_q;

  always_comb begin
    state_d = state_q;
    chip_d  = chip_q;
    div_d   = div_q;
    bit_d   = bit_q;
    guard_d = guard_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    shift_d = shift_q;
    rxd_d   = rxd_q;
    tx_d    = tx_q;
    done_d  = 1'b0;

    if (state_q == S_RX_BIT || state_q == S_TX_BIT) begin
      div_d = tick ? '0 : div_q + DW'(1);
      if (tick) sclk_d = ~sclk_q;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SELECT;
          chip_d  = '0;
          guard_d = '0;
        end
      end
      S_SELECT: begin
        if (guard_q == G_MAX) begin
          state_d = S_RX_BIT;
          div_d   = '0;
          bit_d   = '0;
        end else begin
          guard_d = guard_q + GW'(1);
        end
      end
      S_RX_BIT: begin
        if (rise) shift_d = {shift_q[6:0], spi_miso};
        if (fall) begin
          if (bit_q == RX_LASTB) begin
            state_d = S_RX_HAND;
            rxd_d   = shift_q;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      S_RX_HAND: begin
        if (rx_ready) begin
          state_d = rx_last ? S_WAIT_RES : S_RX_BIT;
          div_d   = '0;
          bit_d   = '0;
        end
      end
      S_WAIT_RES: begin
        if (result_valid) begin
          state_d = S_TX_BIT;
          tx_d    = result_data[RW-2:0];
          mosi_d  = result_data[RW-1];
          div_d   = '0;
          bit_d   = '0;
        end
      end
      S_TX_BIT: begin
        if (fall) begin
          if (bit_q == TX_LASTB) begin
            state_d = S_DESELECT;
            mosi_d  = 1'b0;
            guard_d = '0;
          end else begin
            bit_d  = bit_q + BW'(1);
            mosi_d = tx_q[RW-2];
            tx_d   = {tx_q[RW-3:0], 1'b0};
          end
        end
      end
      S_DESELECT: begin
        if (guard_q == G_MAX) state_d = S_GAP;
        else guard_d = guard_q + GW'(1);
      end
      S_GAP: begin
        guard_d = '0;
        if (chip_q == LAST) begin
          state_d = S_IDLE;
          chip_d  = '0;
          done_d  = 1'b1;
        end else begin
          state_d = S_SELECT;
          chip_d  = chip_q + CIW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      chip_q  <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      guard_q <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      shift_q <= '0;
      rxd_q   <= '0;
      tx_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      chip_q  <= chip_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      guard_q <= guard_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      shift_q <= shift_d;
      rxd_q   <= rxd_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  // Selects follow state, so an async reset drops them at once.
  always_comb begin
    spi_ss_n = '1;
    if (state_q != S_IDLE && state_q != S_GAP) spi_ss_n[chip_q] = 1'b0;
  end

  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;
  assign chip_idx     = chip_q;
  assign spi_sclk     = sclk_q;
  assign spi_mosi     = mosi_q;
  assign rx_data      = rxd_q;
  assign rx_valid     = (state_q == S_RX_HAND);
  assign rx_last      = rx_valid && (rxd_q == 8'h04);
  assign result_ready = (state_q == S_WAIT_RES) && result_valid;

endmodule

// File: tb/tb_spi_chip_sequencer.sv
// tb_spi_chip_sequencer: directed bench for spi_chip_sequencer.
// Slave model streams fixed bytes on MISO and captures MOSI per chip.
module tb_spi_chip_sequencer;

  localparam int NC = 2;
  localparam int CD = 2;
  localparam int RB = 2;
  localparam int SG = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        busy;
  logic        done;
  logic [0:0]  chip_idx;
  logic        spi_sclk;
  logic        spi_mosi;
  logic        spi_miso;
  logic [1:0]  spi_ss_n;
  logic [7:0]  rx_data;
  logic        rx_last;
  logic        rx_valid;
  logic        rx_ready = 1'b1;
  logic [15:0] result_data = '0;
  logic        result_valid = 1'b0;
  logic        result_ready;

  spi_chip_sequencer #(
    .NUM_CHIPS(NC),
    .CLK_DIV(CD),
    .RESULT_BYTES(RB),
    .SS_GUARD(SG)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .busy(busy),
    .done(done),
    .chip_idx(chip_idx),
    .spi_sclk(spi_sclk),
    .spi_mosi(spi_mosi),
    .spi_miso(spi_miso),
    .spi_ss_n(spi_ss_n),
    .rx_data(rx_data),
    .rx_last(rx_last),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .result_data(result_data),
    .result_valid(result_valid),
    .result_ready(result_ready)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;
  int dcnt = 0;

  logic [7:0]  strm [2][8];
  logic [3:0]  slen [2];
  logic [6:0]  bp = '0;
  logic [6:0]  rc = '0;
  logic [15:0] tx_got [2];
  wire         ss_all = &spi_ss_n;

  always_comb begin
    spi_miso = 1'b0;
    if (bp[6:3] < slen[chip_idx])
      spi_miso = strm[chip_idx][bp[5:3]][~bp[2:0]];
  end

  always @(negedge spi_sclk or posedge ss_all)
    if (ss_all) bp <= '0;
    else bp <= bp + 7'd1;

  always @(posedge spi_sclk or posedge ss_all)
    if (ss_all) rc <= '0;
    else begin
      rc <= rc + 7'd1;
      if (rc >= {slen[chip_idx], 3'b000})
        tx_got[chip_idx] <= {tx_got[chip_idx][14:0], spi_mosi};
    end

  always @(posedge clk) if (done) dcnt <= dcnt + 1;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_rxv();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rx_valid && n < 500);
    check("rx_valid_wait", 32'(rx_valid), 1);
  endtask

  task automatic wait_ss(input logic [1:0] exp, input string tag);
    int n = 0;
    while (spi_ss_n !== exp && n < 600) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(spi_ss_n), 32'(exp));
  endtask

  task automatic run_chip(input logic c, input logic [15:0] res,
                          input bit stall, input bit early, input bit poke);
    logic [7:0] d0;
    bit ok;
    int k;
    rx_ready = !stall;
    wait_ss(c ? 2'b01 : 2'b10, "ss_select");
    check("chip_idx", 32'(chip_idx), 32'(c));
    if (poke) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_poke", 32'(busy), 1);
    end
    for (int i = 0; i < int'(slen[c]); i++) begin
      wait_rxv();
      check("rx_data", 32'(rx_data), 32'(strm[c][3'(i)]));
      check("rx_last", 32'(rx_last), 32'(i == int'(slen[c]) - 1));
      if (stall && i == 0) begin
        d0 = rx_data;
        ok = 1'b1;
        repeat (50) begin
          @(negedge clk);
          if (spi_sclk || !rx_valid || rx_data !== d0 || spi_ss_n[0])
            ok = 1'b0;
        end
        check("stall_hold", 32'(ok), 1);
        rx_ready = 1'b1;
      end
    end
    if (early) begin
      result_valid = 1'b1;
      result_data  = res;
      #1;
      check("rr_in_hand", 32'(result_ready), 0);
      @(negedge clk);
      check("rr_first_wait", 32'(result_ready), 1);
    end else begin
      repeat (4) @(negedge clk);
      check("rr_no_valid", 32'(result_ready), 0);
      check("sclk_wait_res", 32'(spi_sclk), 0);
      result_valid = 1'b1;
      result_data  = res;
      #1;
      check("rr_late", 32'(result_ready), 1);
    end
    @(negedge clk);
    result_valid = 1'b0;
    k = 0;
    while (!spi_sclk && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("tx_first_rise", k, CD);
    check("mosi_msb", 32'(spi_mosi), 32'(res[15]));
    wait_ss(2'b11, "ss_release");
    check("tx_bits", 32'(tx_got[c]), 32'(res));
    check("mosi_idle", 32'(spi_mosi), 0);
  endtask

  task automatic run_pass(input logic [15:0] r0, input logic [15:0] r1,
                          input bit st0, input bit e0, input bit e1);
    int d0;
    int n;
    d0 = dcnt;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_start", 32'(busy), 1);
    run_chip(1'b0, r0, st0, e0, 1'b0);
    run_chip(1'b1, r1, 1'b0, e1, 1'b1);
    n = 0;
    while (!done && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("done_pulse", 32'(done), 1);
    check("busy_at_done", 32'(busy), 0);
    check("chip_idx_done", 32'(chip_idx), 0);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 0);
    check("done_count", dcnt - d0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    strm[0][0] = 8'h31;
    strm[0][1] = 8'h0A;
    strm[0][2] = 8'h04;
    slen[0]    = 4'd3;
    strm[1][0] = 8'hC5;
    strm[1][1] = 8'h04;
    slen[1]    = 4'd2;

    #3 rst_n = 1'b0;
    #1;
    check("rst_ctrl", 32'({busy, done, spi_sclk, spi_mosi}), 0);
    check("rst_rx", 32'({rx_valid, rx_last, result_ready}), 0);
    check("rst_ss", 32'(spi_ss_n), 32'h3);
    check("rst_data", 32'({chip_idx, rx_data}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_ss(2'b10, "ss_pre_reset");
    n = 0;
    while (!spi_sclk && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("sclk_in_rx", 32'(spi_sclk), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 0);
    check("arst_ss", 32'(spi_ss_n), 32'h3);
    check("arst_sclk", 32'({spi_sclk, spi_mosi, rx_valid}), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_after_rst", 32'({busy, spi_ss_n}), 32'h3);

    run_pass(16'h1234, 16'hABCD, 1'b1, 1'b0, 1'b1);
    run_pass(16'h00FF, 16'hABCD, 1'b0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
